// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its writeback path.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin arbiter: scans from rr_ptr upward and advances the
// pointer past the granted requester.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] next_ptr_s;
    logic [PTR_W-1:0] scan_s;
    logic [N-1:0]     grant_s;
    logic             hit_s;

    // Pick the first valid requester at or after rr_ptr, wrapping mod N.
    always_comb begin
        grant_s    = '0;
        next_ptr_s = rr_ptr_r;
        scan_s     = '0;
        hit_s      = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                scan_s = PTR_W'((int'(rr_ptr_r) + k) % N);
                if (!hit_s && req[scan_s]) begin
                    grant_s[scan_s] = 1'b1;
                    hit_s           = 1'b1;
                    next_ptr_s      = PTR_W'((int'(scan_s) + 1) % N);
                end else begin
                    hit_s = hit_s;
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    // Pointer only moves on an actual grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (hit_s) begin
            rr_ptr_r <= next_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port, with a registered
// write stage and a per-register pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = REQ_DBG + 1,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_dest,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   wb_stall,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_dest,
    output logic                   rf_write_enable,
    output logic [ADDR_W-1:0]      rf_dest,
    output logic [DATA_W-1:0]      rf_data,
    output logic [(1<<ADDR_W)-1:0] busy,
    output logic [NREQ-1:0]        last_grant
);

    localparam int NREG_L = 1 << ADDR_W;

    logic [NREQ-1:0]   grant_s;
    logic              hs_s;
    logic [ADDR_W-1:0] sel_dest_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [NREG_L-1:0] busy_next_s;

    logic              rf_write_enable_r;
    logic [ADDR_W-1:0] rf_dest_r;
    logic [DATA_W-1:0] rf_data_r;
    logic [NREG_L-1:0] busy_r;
    logic [NREQ-1:0]   last_grant_r;

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (!wb_stall),
        .req   (req_valid),
        .grant (grant_s)
    );

    assign hs_s = |(req_valid & grant_s);

    // Mux the granted requester's dest/data onto the write path.
    always_comb begin
        sel_dest_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_dest_s = req_dest[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_dest_s = sel_dest_s;
            end
        end
    end

    // Clear is applied before set so a same-cycle reservation keeps busy high.
    always_comb begin
        busy_next_s = busy_r;
        if (rf_write_enable_r) begin
            busy_next_s[rf_dest_r] = 1'b0;
        end else begin
            busy_next_s = busy_next_s;
        end
        if (rsv_valid) begin
            busy_next_s[rsv_dest] = 1'b1;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Registered write stage; dest/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write_enable_r <= 1'b0;
            rf_dest_r         <= '0;
            rf_data_r         <= '0;
        end else if (hs_s) begin
            rf_write_enable_r <= 1'b1;
            rf_dest_r         <= sel_dest_s;
            rf_data_r         <= sel_data_s;
        end else begin
            rf_write_enable_r <= 1'b0;
            rf_dest_r         <= rf_dest_r;
            rf_data_r         <= rf_data_r;
        end
    end

    // Scoreboard and debug grant history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r       <= '0;
            last_grant_r <= '0;
        end else begin
            busy_r       <= busy_next_s;
            last_grant_r <= grant_s;
        end
    end

    assign req_ready       = grant_s;
    assign rf_write_enable = rf_write_enable_r;
    assign rf_dest         = rf_dest_r;
    assign rf_data         = rf_data_r;
    assign busy            = busy_r;
    assign last_grant      = last_grant_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_dest;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_stall;
    logic        rsv_valid;
    logic [3:0]  rsv_dest;
    logic        rf_write_enable;
    logic [3:0]  rf_dest;
    logic [15:0] rf_data;
    logic [15:0] busy;
    logic [2:0]  last_grant;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_dest        (req_dest),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .wb_stall        (wb_stall),
        .rsv_valid       (rsv_valid),
        .rsv_dest        (rsv_dest),
        .rf_write_enable (rf_write_enable),
        .rf_dest         (rf_dest),
        .rf_data         (rf_data),
        .busy            (busy),
        .last_grant      (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [2:0]  valid;
        logic [11:0] dest;
        logic [47:0] data;
        logic        stall;
        logic        rsv_v;
        logic [3:0]  rsv_d;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [3:0]  e_dest;
        logic [15:0] e_data;
        logic [15:0] e_busy;
        logic [2:0]  e_last;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [11:0] d,
                                input logic [47:0] x, input logic s, input logic rv,
                                input logic [3:0] rd, input logic [2:0] er, input logic ew,
                                input logic [3:0] ed, input logic [15:0] ex,
                                input logic [15:0] eb, input logic [2:0] el);
        vec_t t;
        t.rst_before = r;  t.valid = v;   t.dest = d;    t.data = x;
        t.stall = s;       t.rsv_v = rv;  t.rsv_d = rd;
        t.e_ready = er;    t.e_we = ew;   t.e_dest = ed; t.e_data = ex;
        t.e_busy = eb;     t.e_last = el;
        return t;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] er, input logic ew,
                             input logic [3:0] ed, input logic [15:0] ex,
                             input logic [15:0] eb, input logic [2:0] el);
        check({tag, " req_ready"},  {45'd0, req_ready},       {45'd0, er});
        check({tag, " write_en"},   {47'd0, rf_write_enable}, {47'd0, ew});
        check({tag, " rf_dest"},    {44'd0, rf_dest},         {44'd0, ed});
        check({tag, " rf_data"},    {32'd0, rf_data},         {32'd0, ex});
        check({tag, " busy"},       {32'd0, busy},            {32'd0, eb});
        check({tag, " last_grant"}, {45'd0, last_grant},      {45'd0, el});
    endtask

    task automatic idle_inputs();
        req_valid = 3'b000; req_dest = 12'h000; req_data = 48'h0;
        wb_stall = 1'b0; rsv_valid = 1'b0; rsv_dest = 4'h0;
    endtask

    // Called at posedge+1; leaves rst low at the next posedge+1.
    task automatic pulse_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Test 1: single request
        vq.push_back(mk(1'b1, 3'b001, 12'h002, 48'h0000_0000_1234, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h002, 48'h0000_0000_1234, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h2, 16'h1234, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b000, 12'h002, 48'h0000_0000_1234, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h2, 16'h1234, 16'h0000, 3'b000));
        // Test 2: full contention
        vq.push_back(mk(1'b1, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b010, 1'b1, 4'h1, 16'h1111, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b100, 1'b1, 4'h2, 16'h2222, 16'h0000, 3'b010));
        vq.push_back(mk(1'b0, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b001, 1'b1, 4'h3, 16'h3333, 16'h0000, 3'b100));
        vq.push_back(mk(1'b0, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b010, 1'b1, 4'h1, 16'h1111, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b111, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b100, 1'b1, 4'h2, 16'h2222, 16'h0000, 3'b010));
        vq.push_back(mk(1'b0, 3'b000, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h3, 16'h3333, 16'h0000, 3'b100));
        vq.push_back(mk(1'b0, 3'b000, 12'h321, 48'h3333_2222_1111, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h3, 16'h3333, 16'h0000, 3'b000));
        // Test 3: scoreboard set/clear, same-cycle set wins, clear by later write
        vq.push_back(mk(1'b1, 3'b000, 12'h000, 48'h0,              1'b0, 1'b1, 4'h5, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h000, 48'h0,              1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0020, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h000, 48'h0,              1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0020, 3'b000));
        vq.push_back(mk(1'b0, 3'b010, 12'h050, 48'h0000_BEEF_0000, 1'b0, 1'b0, 4'h0, 3'b010, 1'b0, 4'h0, 16'h0000, 16'h0020, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h000, 48'h0,              1'b0, 1'b1, 4'h5, 3'b000, 1'b1, 4'h5, 16'hBEEF, 16'h0020, 3'b010));
        vq.push_back(mk(1'b0, 3'b100, 12'h500, 48'hCAFE_0000_0000, 1'b0, 1'b0, 4'h0, 3'b100, 1'b0, 4'h5, 16'hBEEF, 16'h0020, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h000, 48'h0,              1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h5, 16'hCAFE, 16'h0020, 3'b100));
        vq.push_back(mk(1'b0, 3'b000, 12'h000, 48'h0,              1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h5, 16'hCAFE, 16'h0000, 3'b000));
        // Test 4: stall from reset, then stall mid-burst preserving rr_ptr
        vq.push_back(mk(1'b1, 3'b011, 12'h864, 48'h8888_6666_4444, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b011, 12'h864, 48'h8888_6666_4444, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b011, 12'h864, 48'h8888_6666_4444, 1'b1, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b011, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b010, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b010, 1'b1, 4'h4, 16'h4444, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b000, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h6, 16'h6666, 16'h0000, 3'b010));
        vq.push_back(mk(1'b0, 3'b111, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b100, 1'b0, 4'h6, 16'h6666, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b111, 12'h864, 48'h8888_6666_4444, 1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 4'h8, 16'h8888, 16'h0000, 3'b100));
        vq.push_back(mk(1'b0, 3'b111, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h8, 16'h8888, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b000, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h4, 16'h4444, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b000, 12'h864, 48'h8888_6666_4444, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h4, 16'h4444, 16'h0000, 3'b000));
        // Test 6: same dest from requesters 0 and 2
        vq.push_back(mk(1'b1, 3'b101, 12'h707, 48'h5555_0000_AAAA, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000));
        vq.push_back(mk(1'b0, 3'b100, 12'h707, 48'h5555_0000_AAAA, 1'b0, 1'b0, 4'h0, 3'b100, 1'b1, 4'h7, 16'hAAAA, 16'h0000, 3'b001));
        vq.push_back(mk(1'b0, 3'b000, 12'h707, 48'h5555_0000_AAAA, 1'b0, 1'b0, 4'h0, 3'b000, 1'b1, 4'h7, 16'h5555, 16'h0000, 3'b100));
        vq.push_back(mk(1'b0, 3'b000, 12'h707, 48'h5555_0000_AAAA, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h7, 16'h5555, 16'h0000, 3'b000));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000);

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst_before) pulse_reset();
            req_valid = vq[i].valid;  req_dest = vq[i].dest;  req_data = vq[i].data;
            wb_stall  = vq[i].stall;  rsv_valid = vq[i].rsv_v; rsv_dest = vq[i].rsv_d;
            #1;
            check_all($sformatf("v%0d", i), vq[i].e_ready, vq[i].e_we, vq[i].e_dest,
                      vq[i].e_data, vq[i].e_busy, vq[i].e_last);
            @(posedge clk);
            #1;
        end

        // Test 5: asynchronous reset while a write is in flight and busy=0x00FF
        pulse_reset();
        for (int r = 0; r < 8; r++) begin
            rsv_valid = 1'b1;
            rsv_dest  = 4'(r);
            @(posedge clk);
            #1;
        end
        rsv_valid = 1'b0;
        req_valid = 3'b001; req_dest = 12'h003; req_data = 48'h0000_0000_3333;
        #1;
        check_all("t5 grant", 3'b001, 1'b0, 4'h0, 16'h0000, 16'h00FF, 3'b000);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        #1;
        check_all("t5 inflight", 3'b000, 1'b1, 4'h3, 16'h3333, 16'h00FF, 3'b001);
        rst = 1'b1;
        #1;
        check_all("t5 async", 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000);
        @(posedge clk);
        #1;
        check_all("t5 held", 3'b000, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000);
        rst = 1'b0;
        req_valid = 3'b011; req_dest = 12'h0A9; req_data = 48'h0000_A0A0_9090;
        #1;
        check_all("t5 resume", 3'b001, 1'b0, 4'h0, 16'h0000, 16'h0000, 3'b000);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        #1;
        check_all("t5 write", 3'b000, 1'b1, 4'h9, 16'h9090, 16'h0000, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
